// File: rtl/movem_mask_sequencer.sv
// Register-mask sequencer for MOVEM-class multi-register transfers.
// Walks the set bits of a latched mask lowest-first, one transfer per
// accepted cycle, presenting register index and effective address.
module movem_mask_sequencer #(
    parameter int MASK_W = 16,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 24
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MASK_W-1:0] mask,
    input  logic              reverse,
    input  logic              decrement,
    input  logic              long_sz,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              adv,
    output logic              busy,
    output logic              valid,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done,
    output logic              empty,
    output logic [ADDR_W-1:0] final_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [MASK_W-1:0] msk_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              long_r;
    logic              dec_r;
    logic              rev_r;
    logic              empty_r;
    logic [ADDR_W-1:0] final_addr_r;

    logic [IDX_W-1:0]  k_s;
    logic [MASK_W-1:0] msk_clr_s;
    logic [ADDR_W-1:0] step_s;
    logic [ADDR_W-1:0] ptr_dn_s;
    logic [ADDR_W-1:0] ptr_nxt_s;
    logic              last_s;

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [IDX_W-1:0] find_first_set(input logic [MASK_W-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            r = m[i] ? IDX_W'(i) : r;
        end
        return r;
    endfunction

    // Current-bit selection and pointer arithmetic, all from registered state.
    always_comb begin
        k_s            = find_first_set(msk_r);
        msk_clr_s      = msk_r;
        msk_clr_s[k_s] = 1'b0;
        step_s         = long_r ? ADDR_W'(4) : ADDR_W'(2);
        ptr_dn_s       = ptr_r - step_s;
        if (dec_r) begin
            ptr_nxt_s = ptr_dn_s;
        end else begin
            ptr_nxt_s = ptr_r + step_s;
        end
        last_s = (msk_clr_s == '0);
    end

    // Output decode: transfer fields are live only in SCAN, zero otherwise.
    // The mask is walked in its raw order; with reverse set the index is
    // mirrored (MASK_W is a power of two, so MASK_W-1-k is ~k), which gives
    // the predecrement layout where mask bit 0 names the highest register.
    always_comb begin
        busy       = (state_r != IDLE);
        done       = (state_r == DONE);
        empty      = empty_r;
        final_addr = final_addr_r;
        if (state_r == SCAN) begin
            valid   = 1'b1;
            reg_idx = rev_r ? ~k_s : k_s;
            addr    = dec_r ? ptr_dn_s : ptr_r;
            last    = last_s;
        end else begin
            valid   = 1'b0;
            reg_idx = '0;
            addr    = '0;
            last    = 1'b0;
        end
    end

    // Sequencer state machine: load on start, consume bits on adv, abort wins.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            msk_r        <= '0;
            ptr_r        <= '0;
            long_r       <= 1'b0;
            dec_r        <= 1'b0;
            rev_r        <= 1'b0;
            empty_r      <= 1'b0;
            final_addr_r <= '0;
        end else if (abort) begin
            state_r <= IDLE;
            msk_r   <= '0;
            empty_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        msk_r  <= mask;
                        ptr_r  <= base_addr;
                        long_r <= long_sz;
                        dec_r  <= decrement;
                        rev_r  <= reverse;
                        if (mask != '0) begin
                            state_r <= SCAN;
                        end else begin
                            state_r      <= DONE;
                            empty_r      <= 1'b1;
                            final_addr_r <= base_addr;
                        end
                    end
                end
                SCAN: begin
                    if (adv) begin
                        msk_r <= msk_clr_s;
                        ptr_r <= ptr_nxt_s;
                        if (last_s) begin
                            state_r      <= DONE;
                            final_addr_r <= ptr_nxt_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    empty_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_movem_mask_sequencer.sv
// Scoreboard bench for movem_mask_sequencer: stimulus pushes hand-computed
// transfers and done records; a negedge monitor compares and pops them.
module tb_movem_mask_sequencer;

    logic        MCLK = 1'b0;
    logic        reset, start, abort, reverse, decrement, long_sz, adv;
    logic [15:0] mask;
    logic [23:0] base_addr;
    logic        busy, valid, last, done, empty;
    logic [3:0]  reg_idx;
    logic [23:0] addr, final_addr;

    typedef struct {
        bit        is_done;
        logic [3:0]  idx;
        logic [23:0] a;
        bit        lst;
        logic [23:0] fa;
        bit        emp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    movem_mask_sequencer #(.MASK_W(16), .IDX_W(4), .ADDR_W(24)) dut (
        .MCLK(MCLK), .reset(reset), .start(start), .abort(abort), .mask(mask),
        .reverse(reverse), .decrement(decrement), .long_sz(long_sz),
        .base_addr(base_addr), .adv(adv), .busy(busy), .valid(valid),
        .reg_idx(reg_idx), .addr(addr), .last(last), .done(done),
        .empty(empty), .final_addr(final_addr)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_x(input logic [3:0] idx, input logic [23:0] a, input bit lst);
        exp_t e;
        e.is_done = 1'b0; e.idx = idx; e.a = a; e.lst = lst; e.fa = '0; e.emp = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_d(input logic [23:0] fa, input bit emp);
        exp_t e;
        e.is_done = 1'b1; e.idx = '0; e.a = '0; e.lst = 1'b0; e.fa = fa; e.emp = emp;
        q.push_back(e);
    endtask

    // Monitor: every cycle with valid or done is matched against the queue head.
    always @(negedge MCLK) begin
        if (!reset && (valid || done)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'd0, valid, done}, 32'd0);
            end else if (q[0].is_done) begin
                chk("done", {31'd0, done}, 32'd1);
                chk("done_valid", {31'd0, valid}, 32'd0);
                chk("final_addr", {8'd0, final_addr}, {8'd0, q[0].fa});
                chk("empty", {31'd0, empty}, {31'd0, q[0].emp});
                void'(q.pop_front());
            end else begin
                chk("valid", {31'd0, valid}, 32'd1);
                chk("xfer_done", {31'd0, done}, 32'd0);
                chk("reg_idx", {28'd0, reg_idx}, {28'd0, q[0].idx});
                chk("addr", {8'd0, addr}, {8'd0, q[0].a});
                chk("last", {31'd0, last}, {31'd0, q[0].lst});
                chk("busy", {31'd0, busy}, 32'd1);
                if (adv) void'(q.pop_front());
            end
        end
    end

    task automatic issue_start(input logic [15:0] m, input bit r, input bit d,
                               input bit l, input logic [23:0] b);
        @(posedge MCLK); #1;
        mask = m; reverse = r; decrement = d; long_sz = l; base_addr = b; start = 1'b1;
        @(posedge MCLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input logic [23:0] fa);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge MCLK);
            n++;
        end
        chk("drain_timeout", {31'd0, (q.size() != 0)}, 32'd0);
        q.delete();
        @(posedge MCLK); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_final_addr", {8'd0, final_addr}, {8'd0, fa});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; adv = 1'b0;
        mask = '0; reverse = 1'b0; decrement = 1'b0; long_sz = 1'b0; base_addr = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_final", {8'd0, final_addr}, 32'd0);
        reset = 1'b0;

        // Forward walk, word steps
        push_x(4'd0, 24'h001000, 1'b0);
        push_x(4'd8, 24'h001002, 1'b0);
        push_x(4'd15, 24'h001004, 1'b1);
        push_d(24'h001006, 1'b0);
        adv = 1'b1;
        issue_start(16'h8101, 1'b0, 1'b0, 1'b0, 24'h001000);
        wait_drain(24'h001006);

        // Reverse predecrement, long steps
        push_x(4'd15, 24'h001FFC, 1'b0);
        push_x(4'd14, 24'h001FF8, 1'b1);
        push_d(24'h001FF8, 1'b0);
        issue_start(16'h0003, 1'b1, 1'b1, 1'b1, 24'h002000);
        wait_drain(24'h001FF8);

        // Empty mask
        push_d(24'h003000, 1'b1);
        issue_start(16'h0000, 1'b0, 1'b0, 1'b0, 24'h003000);
        wait_drain(24'h003000);

        // adv stall pattern 1,0,0,1,1,1
        push_x(4'd8, 24'h004000, 1'b0);
        push_x(4'd9, 24'h004002, 1'b0);
        push_x(4'd10, 24'h004004, 1'b0);
        push_x(4'd11, 24'h004006, 1'b1);
        push_d(24'h004008, 1'b0);
        issue_start(16'h0F00, 1'b0, 1'b0, 1'b0, 24'h004000);
        begin
            bit [5:0] pat;
            pat = 6'b111001;
            for (int i = 0; i < 6; i++) begin
                adv = pat[i];
                @(posedge MCLK); #1;
            end
        end
        adv = 1'b0;
        wait_drain(24'h004008);

        // Address wrap
        adv = 1'b1;
        push_x(4'd0, 24'hFFFFFE, 1'b0);
        push_x(4'd1, 24'h000000, 1'b1);
        push_d(24'h000002, 1'b0);
        issue_start(16'h0003, 1'b0, 1'b0, 1'b0, 24'hFFFFFE);
        wait_drain(24'h000002);

        // Abort after first transfer, then immediate restart
        push_x(4'd0, 24'h005000, 1'b0);
        push_x(4'd1, 24'h005002, 1'b0);
        issue_start(16'h00FF, 1'b0, 1'b0, 1'b0, 24'h005000);
        @(posedge MCLK); #1;
        abort = 1'b1;
        @(posedge MCLK); #1;
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_final", {8'd0, final_addr}, 32'h000002);
        push_x(4'd4, 24'h006000, 1'b1);
        push_d(24'h006002, 1'b0);
        mask = 16'h0010; base_addr = 24'h006000; start = 1'b1;
        @(posedge MCLK); #1;
        start = 1'b0;
        wait_drain(24'h006002);

        // Reset mid-SCAN clears outputs without a clock edge
        adv = 1'b0;
        push_x(4'd4, 24'h007000, 1'b0);
        issue_start(16'h00F0, 1'b0, 1'b0, 1'b0, 24'h007000);
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_idx", {28'd0, reg_idx}, 32'd0);
        chk("mid_rst_addr", {8'd0, addr}, 32'd0);
        chk("mid_rst_final", {8'd0, final_addr}, 32'd0);
        q.delete();
        @(posedge MCLK); #1;
        reset = 1'b0;
        @(posedge MCLK); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
